// File: rtl/mem_wb_stage_pkg.sv
// Shared definitions for the memory-access stage and ME/WB register.
package mem_wb_stage_pkg;

  localparam int DATA_W_DEFAULT = 32;
  localparam int REG_W          = 5;

  typedef enum logic {
    IDLE   = 1'b0,
    ACCESS = 1'b1
  } state_e;

endpackage

// File: rtl/mem_wb_stage_me_wb_register.sv
// W-side pipeline register: a bubble clears the control bits, a capture
// loads the ME values. Load data is written only when load_rdata is set,
// so stores and ALU ops leave ReadDataW untouched.
module me_wb_register
  import mem_wb_stage_pkg::*;
#(
  parameter int DATA_W = DATA_W_DEFAULT
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              bubble,
  input  logic              capture,
  input  logic              load_rdata,
  input  logic              reg_write,
  input  logic              mem_to_reg,
  input  logic [DATA_W-1:0] alu_result,
  input  logic [DATA_W-1:0] read_data,
  input  logic [REG_W-1:0]  write_reg,
  output logic              reg_write_w,
  output logic              mem_to_reg_w,
  output logic [DATA_W-1:0] alu_result_w,
  output logic [DATA_W-1:0] read_data_w,
  output logic [REG_W-1:0]  write_reg_w
);

  // Pipeline register update: bubble wins over capture, otherwise hold.
  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values regardless of statement order.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      reg_write_w  <= 1'b0;
      mem_to_reg_w <= 1'b0;
      alu_result_w <= '0;
      read_data_w  <= '0;
      write_reg_w  <= '0;
    end else if (bubble) begin
      reg_write_w  <= 1'b0;
      mem_to_reg_w <= 1'b0;
    end else if (capture) begin
      reg_write_w  <= reg_write;
      mem_to_reg_w <= mem_to_reg;
      alu_result_w <= alu_result;
      write_reg_w  <= write_reg;
      if (load_rdata) read_data_w <= read_data;
    end
  end

endmodule

// File: rtl/mem_wb_stage.sv
// Memory-access stage plus ME/WB pipeline register. Drives a variable-latency
// data memory through a registered req/ready handshake and stalls the front
// of the pipeline while an access is outstanding. Only one request is ever in
// flight, so loads retire in order.
// Optional build macro MEM_TIMEOUT_EN: aborts an access after TIMEOUT_CYCLES
// ACCESS cycles without mem_ready and raises the sticky MemErrW output.
module mem_wb_stage
  import mem_wb_stage_pkg::*;
#(
  parameter int DATA_W = DATA_W_DEFAULT
`ifdef MEM_TIMEOUT_EN
  , parameter int TIMEOUT_CYCLES = 16
`endif
) (
  input  logic              Clock,
  input  logic              Reset_n,
  input  logic              ValidM,
  input  logic              RegWriteM,
  input  logic              MemtoRegM,
  input  logic              MemWriteM,
  input  logic [DATA_W-1:0] ALUResultM,
  input  logic [DATA_W-1:0] WriteDataM,
  input  logic [REG_W-1:0]  WriteRegM,
  output logic              mem_req,
  output logic              mem_we,
  output logic [DATA_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic              mem_ready,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic              StallM,
  output logic              RegWriteW,
  output logic              MemtoRegW,
  output logic [DATA_W-1:0] ALUResultW,
  output logic [DATA_W-1:0] ReadDataW,
  output logic [REG_W-1:0]  WriteRegW,
  output logic [DATA_W-1:0] ResultW,
  output logic              MisalignW
`ifdef MEM_TIMEOUT_EN
  , output logic            MemErrW
`endif
);

  state_e state, state_n;
  logic   mem_access, memop, misaligned, timeout;
  logic   start, finish, abort, set_misalign;
  logic   wb_bubble, wb_capture, wb_load_rdata;

  assign mem_access = ValidM & (MemtoRegM | MemWriteM);
  assign memop      = mem_access & (ALUResultM[1:0] == 2'b00);
  assign misaligned = mem_access & (ALUResultM[1:0] != 2'b00);

`ifdef MEM_TIMEOUT_EN
  logic [4:0] access_cnt;

  // Count ACCESS cycles; restart from zero on every new request.
  always_ff @(posedge Clock or negedge Reset_n) begin
    if (!Reset_n)              access_cnt <= '0;
    else if (start)            access_cnt <= '0;
    else if (state == ACCESS)  access_cnt <= access_cnt + 5'd1;
  end

  assign timeout = (state == ACCESS) && (access_cnt == 5'(TIMEOUT_CYCLES - 1));

  // Sticky memory-error flag, set when an access is aborted.
  always_ff @(posedge Clock or negedge Reset_n) begin
    if (!Reset_n)   MemErrW <= 1'b0;
    else if (abort) MemErrW <= 1'b1;
  end
`else
  assign timeout = 1'b0;
`endif

  // Next-state, stall and WB-register control.
  // NOTE: every output gets a default first so no path infers a latch.
  always_comb begin
    state_n       = state;
    StallM        = 1'b0;
    start         = 1'b0;
    finish        = 1'b0;
    abort         = 1'b0;
    set_misalign  = 1'b0;
    wb_bubble     = 1'b0;
    wb_capture    = 1'b0;
    wb_load_rdata = 1'b0;
    case (state)
      IDLE: begin
        if (memop) begin
          StallM    = 1'b1;
          start     = 1'b1;
          wb_bubble = 1'b1;
          state_n   = ACCESS;
        end else if (misaligned) begin
          set_misalign = 1'b1;
          wb_bubble    = 1'b1;
        end else begin
          wb_capture = 1'b1;
        end
      end
      ACCESS: begin
        if (mem_ready) begin
          finish        = 1'b1;
          wb_capture    = 1'b1;
          wb_load_rdata = MemtoRegM;
          state_n       = IDLE;
        end else if (timeout) begin
          finish    = 1'b1;
          abort     = 1'b1;
          wb_bubble = 1'b1;
          state_n   = IDLE;
        end else begin
          StallM    = 1'b1;
          wb_bubble = 1'b1;
        end
      end
      default: state_n = IDLE;
    endcase
  end

  // FSM state register.
  always_ff @(posedge Clock or negedge Reset_n) begin
    if (!Reset_n) state <= IDLE;
    else          state <= state_n;
  end

  // Memory port: launch on request, hold while waiting, drop on completion.
  always_ff @(posedge Clock or negedge Reset_n) begin
    if (!Reset_n) begin
      mem_req   <= 1'b0;
      mem_we    <= 1'b0;
      mem_addr  <= '0;
      mem_wdata <= '0;
    end else if (start) begin
      mem_req   <= 1'b1;
      mem_we    <= MemWriteM;
      mem_addr  <= ALUResultM;
      mem_wdata <= WriteDataM;
    end else if (finish) begin
      mem_req   <= 1'b0;
      mem_we    <= 1'b0;
    end
  end

  // Sticky misaligned-access flag.
  always_ff @(posedge Clock or negedge Reset_n) begin
    if (!Reset_n)          MisalignW <= 1'b0;
    else if (set_misalign) MisalignW <= 1'b1;
  end

  me_wb_register #(.DATA_W(DATA_W)) u_me_wb_register (
    .clk          (Clock),
    .rst_n        (Reset_n),
    .bubble       (wb_bubble),
    .capture      (wb_capture),
    .load_rdata   (wb_load_rdata),
    .reg_write    (RegWriteM & ValidM),
    .mem_to_reg   (MemtoRegM & ValidM),
    .alu_result   (ALUResultM),
    .read_data    (mem_rdata),
    .write_reg    (WriteRegM),
    .reg_write_w  (RegWriteW),
    .mem_to_reg_w (MemtoRegW),
    .alu_result_w (ALUResultW),
    .read_data_w  (ReadDataW),
    .write_reg_w  (WriteRegW)
  );

  // Writeback mux, also used by the WB-to-EX forwarding path.
  assign ResultW = MemtoRegW ? ReadDataW : ALUResultW;

endmodule

// File: tb/tb_mem_wb_stage.sv
// Self-checking bench for mem_wb_stage: expected W-side results are queued
// when an instruction is driven and compared when it retires.
module tb_mem_wb_stage;
  import mem_wb_stage_pkg::*;

  logic        Clock = 1'b0;
  logic        Reset_n = 1'b0;
  logic        ValidM, RegWriteM, MemtoRegM, MemWriteM;
  logic [31:0] ALUResultM, WriteDataM;
  logic [4:0]  WriteRegM;
  logic        mem_req, mem_we, mem_ready;
  logic [31:0] mem_addr, mem_wdata, mem_rdata;
  logic        StallM, RegWriteW, MemtoRegW, MisalignW;
  logic [31:0] ALUResultW, ReadDataW, ResultW;
  logic [4:0]  WriteRegW;
`ifdef MEM_TIMEOUT_EN
  logic        MemErrW;
`endif

  mem_wb_stage #(
    .DATA_W(32)
`ifdef MEM_TIMEOUT_EN
    , .TIMEOUT_CYCLES(4)
`endif
  ) dut (
    .Clock(Clock), .Reset_n(Reset_n), .ValidM(ValidM), .RegWriteM(RegWriteM),
    .MemtoRegM(MemtoRegM), .MemWriteM(MemWriteM), .ALUResultM(ALUResultM),
    .WriteDataM(WriteDataM), .WriteRegM(WriteRegM), .mem_req(mem_req),
    .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_ready(mem_ready), .mem_rdata(mem_rdata), .StallM(StallM),
    .RegWriteW(RegWriteW), .MemtoRegW(MemtoRegW), .ALUResultW(ALUResultW),
    .ReadDataW(ReadDataW), .WriteRegW(WriteRegW), .ResultW(ResultW),
    .MisalignW(MisalignW)
`ifdef MEM_TIMEOUT_EN
    , .MemErrW(MemErrW)
`endif
  );

  always #5 Clock = ~Clock;

  typedef struct {
    logic        reg_write;
    logic        mem_to_reg;
    logic [4:0]  write_reg;
    logic [31:0] result;
    bit          chk_data;
  } wb_exp_t;

  wb_exp_t sb[$];
  logic    misalign_exp = 1'b0;
  int      n_compared   = 0;
  int      n_mismatched = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_compared++;
    if (got !== exp) begin
      n_mismatched++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  task automatic drive_idle();
    ValidM = 1'b0; RegWriteM = 1'b0; MemtoRegM = 1'b0; MemWriteM = 1'b0;
    ALUResultM = '0; WriteDataM = '0; WriteRegM = '0;
    mem_ready = 1'b0; mem_rdata = '0;
  endtask

  // Drive one instruction just after a rising edge, act as a memory that
  // answers after 'waits' ACCESS cycles, then compare the retired W values.
  task automatic issue(input logic valid, input logic rw, input logic m2r, input logic mw,
                       input logic [31:0] alu, input logic [31:0] wdata, input logic [4:0] wreg,
                       input int waits, input logic [31:0] rdata, input logic idle_ready);
    bit      memop, mis, done;
    int      stalls, acc;
    wb_exp_t e;
    memop  = valid && (m2r || mw) && (alu[1:0] == 2'b00);
    mis    = valid && (m2r || mw) && (alu[1:0] != 2'b00);
    done   = 1'b0;
    stalls = 0;
    acc    = 0;
    ValidM = valid; RegWriteM = rw; MemtoRegM = m2r; MemWriteM = mw;
    ALUResultM = alu; WriteDataM = wdata; WriteRegM = wreg;
    mem_ready = memop ? 1'b0 : idle_ready;
    mem_rdata = 32'hFFFF_0000;
    e.reg_write  = valid && rw && !mis;
    e.mem_to_reg = valid && m2r && !mis;
    e.write_reg  = wreg;
    e.result     = m2r ? rdata : alu;
    e.chk_data   = valid && !mis;
    if (mis) misalign_exp = 1'b1;
    sb.push_back(e);
    for (int cyc = 0; cyc < 64 && !done; cyc++) begin
      @(negedge Clock);
      if (mem_req) begin
        check("mem_addr_held", mem_addr, alu);
        check("mem_we_held", 32'(mem_we), 32'(mw));
        check("mem_wdata_held", mem_wdata, wdata);
        check("RegWriteW_bubble", 32'(RegWriteW), 32'd0);
        if (acc == waits) begin
          mem_ready = 1'b1;
          mem_rdata = rdata;
        end
        acc++;
      end
      #1;
      if (StallM) stalls++;
      else        done = 1'b1;
    end
    check("retire_within_budget", 32'(done), 32'd1);
    @(posedge Clock);
    #1;
    mem_ready = 1'b0;
    check("scoreboard_nonempty", 32'(sb.size() != 0), 32'd1);
    if (sb.size() != 0) begin
      e = sb.pop_front();
      check("StallM_cycles", 32'(stalls), 32'(memop ? waits + 1 : 0));
      check("mem_req_dropped", 32'(mem_req), 32'd0);
      check("RegWriteW", 32'(RegWriteW), 32'(e.reg_write));
      check("MemtoRegW", 32'(MemtoRegW), 32'(e.mem_to_reg));
      check("MisalignW", 32'(MisalignW), 32'(misalign_exp));
      if (e.chk_data) begin
        check("WriteRegW", 32'(WriteRegW), 32'(e.write_reg));
        check("ResultW", ResultW, e.result);
      end
    end
  endtask

  initial begin
    drive_idle();
    #12;
    // Reset state
    check("rst_mem_req", 32'(mem_req), 32'd0);
    check("rst_mem_we", 32'(mem_we), 32'd0);
    check("rst_mem_addr", mem_addr, 32'd0);
    check("rst_mem_wdata", mem_wdata, 32'd0);
    check("rst_StallM", 32'(StallM), 32'd0);
    check("rst_RegWriteW", 32'(RegWriteW), 32'd0);
    check("rst_MemtoRegW", 32'(MemtoRegW), 32'd0);
    check("rst_ALUResultW", ALUResultW, 32'd0);
    check("rst_ReadDataW", ReadDataW, 32'd0);
    check("rst_WriteRegW", 32'(WriteRegW), 32'd0);
    check("rst_ResultW", ResultW, 32'd0);
    check("rst_MisalignW", 32'(MisalignW), 32'd0);
    @(negedge Clock);
    Reset_n = 1'b1;
    @(posedge Clock);
    #1;

    // ALU pass-through, with a stray mem_ready in IDLE that must be ignored
    issue(1, 1, 0, 0, 32'h0000_0007, 32'h0, 5'd9, 0, 32'h0, 1);
    // Zero-wait load
    issue(1, 1, 1, 0, 32'h0000_0040, 32'h0, 5'd5, 0, 32'hDEAD_BEEF, 0);
    // Wait-state store, ready after 3 cycles
    issue(1, 0, 0, 1, 32'h0000_0080, 32'h1234_5678, 5'd0, 3, 32'h0, 0);
    // ALU op with non-zero low address bits is not a memory access
    issue(1, 1, 0, 0, 32'hA5A5_0003, 32'h0, 5'd31, 0, 32'h0, 0);
    // Load with two wait states, then back-to-back ALU op
    issue(1, 1, 1, 0, 32'h0000_01FC, 32'h0, 5'd17, 2, 32'h0BAD_F00D, 0);
    issue(1, 1, 0, 0, 32'h1111_2222, 32'h0, 5'd4, 0, 32'h0, 0);
    // Invalid slot: no register write
    issue(0, 1, 0, 0, 32'h3333_4444, 32'h0, 5'd6, 0, 32'h0, 0);
    // Misaligned load, then ALU op to see the flag stay set
    issue(1, 1, 1, 0, 32'h0000_0042, 32'h0, 5'd8, 0, 32'h0, 0);
    issue(1, 1, 0, 0, 32'h0000_00AA, 32'h0, 5'd2, 0, 32'h0, 0);

    // Random aligned mix
    for (int i = 0; i < 8; i++) begin
      int          op;
      logic [31:0] a;
      op = int'($urandom_range(0, 2));
      a  = $urandom() & 32'hFFFF_FFFC;
      issue(1, op != 2, op == 1, op == 2, a, $urandom(), 5'($urandom_range(1, 31)),
            int'($urandom_range(0, 3)), $urandom(), 0);
    end

`ifdef MEM_TIMEOUT_EN
    // Access timeout with mem_ready held low
    begin
      int stalls;
      bit done;
      stalls = 0;
      done   = 1'b0;
      drive_idle();
      ValidM = 1'b1; RegWriteM = 1'b1; MemtoRegM = 1'b1;
      ALUResultM = 32'h0000_0200; WriteRegM = 5'd12;
      for (int cyc = 0; cyc < 64 && !done; cyc++) begin
        @(negedge Clock);
        #1;
        if (StallM) stalls++;
        else        done = 1'b1;
      end
      check("to_stall_cycles", 32'(stalls), 32'd4);
      @(posedge Clock);
      #1;
      check("to_MemErrW", 32'(MemErrW), 32'd1);
      check("to_RegWriteW", 32'(RegWriteW), 32'd0);
      check("to_mem_req", 32'(mem_req), 32'd0);
      drive_idle();
      @(posedge Clock);
      #1;
    end
`endif

    // Reset in the middle of an access
    drive_idle();
    ValidM = 1'b1; RegWriteM = 1'b1; MemtoRegM = 1'b1;
    ALUResultM = 32'h0000_0100; WriteRegM = 5'd3;
    @(negedge Clock);
    @(negedge Clock);
    check("mid_req_before_rst", 32'(mem_req), 32'd1);
    Reset_n = 1'b0;
    #1;
    check("mid_req_at_rst", 32'(mem_req), 32'd0);
    drive_idle();
    misalign_exp = 1'b0;
    sb.delete();
    @(negedge Clock);
    Reset_n   = 1'b1;
    mem_ready = 1'b1;
    mem_rdata = 32'hBAD0_BAD0;
    for (int i = 0; i < 3; i++) begin
      @(negedge Clock);
      check("mid_mem_req", 32'(mem_req), 32'd0);
      check("mid_StallM", 32'(StallM), 32'd0);
      check("mid_RegWriteW", 32'(RegWriteW), 32'd0);
      check("mid_MemtoRegW", 32'(MemtoRegW), 32'd0);
      check("mid_ReadDataW", ReadDataW, 32'd0);
      check("mid_ResultW", ResultW, 32'd0);
      check("mid_WriteRegW", 32'(WriteRegW), 32'd0);
      check("mid_MisalignW", 32'(MisalignW), 32'd0);
    end
    mem_ready = 1'b0;
    @(posedge Clock);
    #1;
    // Recovery after reset
    issue(1, 1, 1, 0, 32'h0000_0010, 32'h0, 5'd7, 1, 32'hCAFE_F00D, 0);
    issue(1, 1, 0, 0, 32'h0000_0055, 32'h0, 5'd1, 0, 32'h0, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_compared, n_mismatched);
    $finish;
  end

endmodule

// File: doc/mem_wb_stage.md
Name: mem_wb_stage

Overview:
- Memory-access stage plus ME/WB pipeline register, directly downstream of the EX/ME register of the 5-stage MIPS pipeline.
- Consumes the ME-side control and data (RegWriteM, MemtoRegM, MemWriteM, ALUResultM, WriteDataM, WriteRegM) and drives a variable-latency data-memory port through a req/ready handshake.
- Stalls the front of the pipeline while an access is outstanding.
- Presents W-side values, including ResultW, which also feeds the EX-stage WB-to-EX forwarding path.

Parameters:
- DATA_W, 32, data and address width.
- TIMEOUT_CYCLES, 16, maximum ACCESS cycles before abort (used only with MEM_TIMEOUT_EN).

Ports:
- Clock  in  1  pipeline clock, rising edge.
- Reset_n  in  1  asynchronous, active-low reset.
- ValidM  in  1  ME slot holds a real instruction.
- RegWriteM  in  1  instruction writes the register file.
- MemtoRegM  in  1  load (writeback value comes from memory).
- MemWriteM  in  1  store.
- ALUResultM  in  DATA_W  effective address, or ALU result.
- WriteDataM  in  DATA_W  store data.
- WriteRegM  in  5  destination register.
- mem_req  out  1  memory request, registered.
- mem_we  out  1  1 = write, registered.
- mem_addr  out  DATA_W  word address, registered.
- mem_wdata  out  DATA_W  store data, registered.
- mem_ready  in  1  memory completes the request this cycle.
- mem_rdata  in  DATA_W  load data, valid with mem_ready.
- StallM  out  1  freeze PC, IF/ID, ID/EX and EX/ME; combinational.
- RegWriteW  out  1  registered.
- MemtoRegW  out  1  registered.
- ALUResultW  out  DATA_W  registered.
- ReadDataW  out  DATA_W  registered.
- WriteRegW  out  5  registered.
- ResultW  out  DATA_W  MemtoRegW ? ReadDataW : ALUResultW; combinational.
- MisalignW  out  1  sticky misaligned-access flag.

Behaviour:
- Reset (async, Reset_n=0): FSM=IDLE; mem_req, mem_we, RegWriteW, MemtoRegW and MisalignW =0; all data outputs and WriteRegW =0. Reset during ACCESS drops mem_req immediately and discards the access; any late mem_ready is ignored.
- memop = ValidM & (MemtoRegM | MemWriteM) & (ALUResultM[1:0]==0).
- misaligned = ValidM & (MemtoRegM | MemWriteM) & (ALUResultM[1:0]!=0).
- FSM states: IDLE, ACCESS.
- IDLE, memop: on the next edge go to ACCESS and register mem_req=1, mem_we=MemWriteM, mem_addr=ALUResultM, mem_wdata=WriteDataM. StallM=1 this cycle. The WB register loads a bubble (RegWriteW=0, MemtoRegW=0).
- IDLE, non-memop: single-cycle pass-through. The WB register captures the M values; RegWriteW = RegWriteM & ValidM.
- IDLE, misaligned: no memory request. MisalignW is set (sticky until reset). A bubble is loaded and no stall occurs.
- ACCESS, mem_ready=0: hold mem_req and all mem_* values stable. StallM=1. Load a bubble into WB.
- ACCESS, mem_ready=1: StallM=0. The WB register captures RegWriteM/MemtoRegM/ALUResultM/WriteRegM and ReadDataW=mem_rdata (stores leave ReadDataW at its old value, RegWriteW=RegWriteM). Drop mem_req and return to IDLE on the same edge, so the next instruction enters IDLE on the following cycle.
- Minimum load/store latency to W: 2 cycles after entering ME. A zero-wait memory (mem_ready=1 in the first ACCESS cycle) gives exactly one stall cycle.
- Loads retire in order: only one request is ever outstanding.
- mem_ready sampled in IDLE is ignored.
- ValidM=0: treated as a non-memop bubble; RegWriteW=0.

Optional Feature:
- Macro MEM_TIMEOUT_EN.
- Defined: a 5-bit ACCESS cycle counter, cleared on entry to ACCESS. When the count reaches TIMEOUT_CYCLES-1 with mem_ready still low, the block drops mem_req, returns to IDLE and loads a bubble into WB (the instruction is squashed). It also sets the sticky output MemErrW (extra port, 1 bit, reset 0).
- Undefined: no counter and no MemErrW port; ACCESS waits indefinitely for mem_ready.

Decomposition:
- Shared package: FSM state encoding (IDLE=1'b0, ACCESS=1'b1), DATA_W default, and the register-number width constant (5).
- Natural sub-module: me_wb_register (the W-side pipeline register with bubble-load and capture enables). The FSM and memory-port logic stay in mem_wb_stage.

Test Plan:
- ALU pass-through: ValidM=1, RegWriteM=1, ALUResultM=0x0000_0007, WriteRegM=9 -> next edge RegWriteW=1, WriteRegW=9, ResultW=7; StallM never asserted.
- Zero-wait load: MemtoRegM=1, ALUResultM=0x40, mem_ready=1 with mem_rdata=0xDEAD_BEEF in the first ACCESS cycle -> exactly 1 StallM cycle, mem_addr=0x40, mem_we=0; then ResultW=0xDEAD_BEEF and RegWriteW=1.
- Wait-state store: MemWriteM=1, addr 0x80, data 0x1234_5678, mem_ready after 3 cycles -> StallM high for 4 cycles; mem_req/mem_we/addr/wdata held stable throughout; RegWriteW=0 throughout.
- Misaligned load: ALUResultM=0x42 -> mem_req stays 0, MisalignW=1, RegWriteW=0, no stall.
- Reset mid-access: Reset_n pulsed low during ACCESS -> mem_req=0 immediately, FSM=IDLE; a later mem_ready=1 is ignored and all W outputs stay 0.
- MEM_TIMEOUT_EN with TIMEOUT_CYCLES=4 and mem_ready held low -> abort after 4 ACCESS cycles, MemErrW=1, RegWriteW=0, StallM releases.
